// File: rtl/cc_frame_receive.sv
// cc_frame_receive: CC packet stream receiver.
// Recovers 8N1 UART bytes from rx, hunts for the 0x55 0xAA sync pair, packs
// little-endian payload bytes into 32-bit words for an external word RAM and
// flags frame completion (frame_rdy) or abort (frame_err).
// Optional feature macro: CC_RX_CHECKSUM_EN adds a trailing XOR checksum byte
// and the CHECK state; without it the frame completes after the last word.
`timescale 1ns/1ps
module cc_frame_receive #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORDS        = 512,
  parameter int TIMEOUT      = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_rdy,
  output logic [3:0]  frame_cnt,
  output logic        frame_err,
  output logic        busy
);

  localparam int BIT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [9:0]        LAST_ADDR = 10'(WORDS - 1);
  // The counter holds clocks elapsed since the last byte; the abort is taken
  // on the cycle it would reach TIMEOUT so frame_err lands TIMEOUT clocks
  // after that byte.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  localparam logic [7:0] SYNC1 = 8'h55;
  localparam logic [7:0] SYNC2 = 8'hAA;

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state;
  rx_state_t        rx_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             bit_tick;
  logic [7:0]       rx_shift;
  logic             byte_ok;
  logic             byte_bad;

  // A tick marks the cycle on which the current bit is sampled
  always_comb begin
    bit_tick = 1'b0;
    case (rx_state)
      RX_START: bit_tick = (bit_cnt == HALF_LAST);
      RX_DATA:  bit_tick = (bit_cnt == BIT_LAST);
      RX_STOP:  bit_tick = (bit_cnt == BIT_LAST);
      default:  bit_tick = 1'b0;
    endcase
  end

  // Byte receiver state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // Byte receiver next state: a high start-bit re-sample is a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (bit_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && (bit_idx == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timing counters and the one-cycle byte_ok / byte_bad pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
    end else begin
      if ((rx_state == RX_IDLE) || bit_tick) bit_cnt <= '0;
      else                                   bit_cnt <= bit_cnt + 1'b1;

      if (rx_state == RX_START)            bit_idx <= '0;
      else if ((rx_state == RX_DATA) && bit_tick) bit_idx <= bit_idx + 1'b1;

      byte_ok  <= (rx_state == RX_STOP) && bit_tick &&  rx_sync;
      byte_bad <= (rx_state == RX_STOP) && bit_tick && !rx_sync;
    end
  end

  // Data bits arrive LSB first; the byte stays stable until the next data phase
  always_ff @(posedge clock) begin
    if ((rx_state == RX_DATA) && bit_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
`ifdef CC_RX_CHECKSUM_EN
  typedef enum logic [2:0] {
    HUNT_S1,
    HUNT_S2,
    PAYLOAD,
    CHECK,
    DONE,
    ERR
  } frame_state_t;
`else
  typedef enum logic [2:0] {
    HUNT_S1,
    HUNT_S2,
    PAYLOAD,
    DONE,
    ERR
  } frame_state_t;
`endif

  frame_state_t      state;
  frame_state_t      state_next;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sr;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;
  logic              enter_payload;
  logic              last_write;

`ifdef CC_RX_CHECKSUM_EN
  logic [7:0] xor_acc;
`endif

  // A byte arriving in the same cycle as the timeout keeps the frame alive
  assign timeout       = !byte_ok && (idle_cnt == IDLE_LAST);
  assign enter_payload = (state == HUNT_S2) && byte_ok && (rx_shift == SYNC2);
  assign last_write    = wr_en && (wr_addr == LAST_ADDR);

  // Frame state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HUNT_S1;
    else       state <= state_next;
  end

  // Frame next state: sync hunt, payload, optional checksum, completion
  always_comb begin
    state_next = state;
    case (state)
      HUNT_S1: begin
        if (byte_ok && (rx_shift == SYNC1)) state_next = HUNT_S2;
      end
      HUNT_S2: begin
        if (byte_ok) begin
          if (rx_shift == SYNC2)      state_next = PAYLOAD;
          else if (rx_shift != SYNC1) state_next = HUNT_S1;
        end
      end
      PAYLOAD: begin
        if (byte_bad)        state_next = ERR;
`ifdef CC_RX_CHECKSUM_EN
        else if (last_write) state_next = CHECK;
`else
        else if (last_write) state_next = DONE;
`endif
        else if (timeout)    state_next = ERR;
      end
`ifdef CC_RX_CHECKSUM_EN
      CHECK: begin
        if (byte_ok)                 state_next = (rx_shift == xor_acc) ? DONE : ERR;
        else if (byte_bad || timeout) state_next = ERR;
      end
`endif
      DONE:    state_next = HUNT_S1;
      ERR:     state_next = HUNT_S1;
      default: state_next = HUNT_S1;
    endcase
  end

  // Frame status outputs decoded from the state
  always_comb begin
    frame_rdy = (state == DONE);
    frame_err = (state == ERR);
`ifdef CC_RX_CHECKSUM_EN
    busy      = (state == PAYLOAD) || (state == CHECK);
`else
    busy      = (state == PAYLOAD);
`endif
  end

  // Word write port, byte-in-word counter and inter-byte idle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      byte_idx <= '0;
      idle_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (enter_payload) begin
        wr_addr  <= '0;
        byte_idx <= '0;
        idle_cnt <= '0;
      end else if (busy) begin
        if (byte_ok) idle_cnt <= IDLE_W'(1);
        else         idle_cnt <= idle_cnt + 1'b1;

        if (wr_en) wr_addr <= wr_addr + 1'b1;

        if ((state == PAYLOAD) && byte_ok) begin
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            wr_en   <= 1'b1;
            wr_data <= {rx_shift, word_sr};
          end
        end
      end
    end
  end

  // Little-endian assembly: earlier bytes slide toward the low end of the word
  always_ff @(posedge clock) begin
    if ((state == PAYLOAD) && byte_ok) word_sr <= {rx_shift, word_sr[23:8]};
  end

`ifdef CC_RX_CHECKSUM_EN
  // Running XOR of every payload byte, compared against the trailer byte
  always_ff @(posedge clock) begin
    if (enter_payload)                      xor_acc <= 8'h00;
    else if ((state == PAYLOAD) && byte_ok) xor_acc <= xor_acc ^ rx_shift;
  end
`endif

  // Accepted-frame counter, wraps 15 -> 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
  end

endmodule

// File: doc/cc_frame_receive.md
# cc_frame_receive

Serial receiver for the CC packet stream produced by the frame assembler/transmitter (sound words plus flight parameters). It recovers 8N1 UART bytes from `rx`, hunts for the frame sync pair, and assembles little-endian payload bytes into 32-bit words. Each word is written to an external word RAM, and the block flags frame completion or error. It sits on the ground/test side of the CC link and feeds frame consumers (playback, parameter decode).

## Interface
- `CLKS_PER_BIT`, 434 — clocks per UART bit; must be ≥ 4.
- `WORDS`, 512 — payload words per frame (500 sound + 12 flight params); must be ≤ 1024.
- `TIMEOUT`, 65535 — max idle clocks between bytes inside a frame.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, idle high, asynchronous to `clock`.
- `wr_en`  out  1  one-cycle word write strobe.
- `wr_addr`  out  10  word index within the frame, 0..WORDS-1.
- `wr_data`  out  32  assembled word; byte 0 received sits in [7:0].
- `frame_rdy`  out  1  one-cycle pulse: frame accepted.
- `frame_cnt`  out  4  count of accepted frames, wraps 15→0.
- `frame_err`  out  1  one-cycle pulse: frame aborted.
- `busy`  out  1  high while in PAYLOAD or CHECK.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- **Byte receiver**
  - Idle until the synchronized `rx` falls.
  - At CLKS_PER_BIT/2, re-sample the start bit. If `rx` is high, treat it as a glitch and return to idle with no byte.
  - Sample 8 data bits, LSB first, every CLKS_PER_BIT.
  - Sample the stop bit. Stop = 1 gives `byte_ok` for one cycle; stop = 0 gives `byte_bad` for one cycle.
  - After either outcome, return to idle immediately; the receiver rearms on the next falling edge.
- **Frame FSM**
  - HUNT_S1: `byte_ok` with 0x55 goes to HUNT_S2; any other byte stays in HUNT_S1.
  - HUNT_S2: 0xAA goes to PAYLOAD; 0x55 stays in HUNT_S2; any other byte goes to HUNT_S1.
  - PAYLOAD: shift bytes into a 32-bit assembler.
    - On the 4th byte of a word, pulse `wr_en` with the current `wr_addr`, then increment `wr_addr`.
    - After the write of word WORDS-1, go to CHECK (macro set) or DONE.
  - CHECK: next `byte_ok` is compared with the running XOR of all payload bytes. Match goes to DONE; mismatch goes to ERR.
  - DONE: pulse `frame_rdy`, increment `frame_cnt`, go to HUNT_S1.
  - ERR: pulse `frame_err`, go to HUNT_S1; `frame_cnt` is unchanged.
- **Abort conditions** (each goes to ERR): `byte_bad` in PAYLOAD or CHECK; idle counter reaching TIMEOUT in PAYLOAD or CHECK.
- **Hunt states**: `byte_bad` is dropped silently; no timeout applies.
- Entering PAYLOAD clears `wr_addr`, the byte-in-word counter, the XOR accumulator and the idle counter.
- Words already written for an aborted frame stay in the RAM; consumers act only on `frame_rdy`.

## Timing
- **Reset values**: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_rdy`=0, `frame_cnt`=0, `frame_err`=0, `busy`=0; FSM in HUNT_S1; byte receiver idle. Reset asserted mid-frame discards everything.
- **Bit sampling**: the stop-bit sample falls 9.5·CLKS_PER_BIT (±1) clocks after the synchronized falling edge. `byte_ok`/`byte_bad` fire on the cycle after that sample.
- **Word write**: `wr_en`, `wr_addr` and `wr_data` are registered, valid together 1 cycle after the 4th `byte_ok`. `wr_addr` increments on the cycle after `wr_en`.
- **Frame completion**:
  - Macro clear: `frame_rdy` comes 1 cycle after the final `wr_en`.
  - Macro set: `frame_rdy` or `frame_err` comes 1 cycle after the checksum `byte_ok`.
- **Simultaneous events**: the idle counter resets on every `byte_ok`. If timeout and `byte_ok` occur in the same cycle, the byte wins.
- **Resync**: after `frame_rdy` or `frame_err`, the block is ready for a new sync pair on the next cycle. A sync pair arriving inside PAYLOAD is treated as data.

## Configuration
- `CC_RX_CHECKSUM_EN` defined: the frame carries one trailer byte after the payload, equal to the XOR of all 4·WORDS payload bytes. The CHECK state is present, and a mismatch produces `frame_err`.
- Undefined: no trailer byte, no CHECK state and no XOR logic. `frame_rdy` follows the last word write.

## Test plan
- **Basic frame**: CLKS_PER_BIT=8, WORDS=4; send 55 AA then 16 bytes 01..10 → four `wr_en`, with (addr 0, 0x04030201) first and (addr 3, 0x100F0E0D) last; one `frame_rdy`; `frame_cnt`=1.
- **Sync hunt**: send 55 55 12 55 AA followed by a valid frame → only one frame accepted; the 0x12 byte forces a rehunt, and the repeated 55 is tolerated.
- **Framing error**: force stop bit 0 on payload byte 6 → `frame_err` pulses once; `frame_cnt` unchanged; the next clean frame is accepted.
- **Timeout**: TIMEOUT=200; hold `rx` high after payload byte 9 → `frame_err` 200 clocks after the last `byte_ok`; `busy` drops.
- **Checksum** (macro set): send a correct XOR trailer → `frame_rdy`; send the trailer XOR 0x01 → `frame_err`.
- **Misc**: a 2-clock low glitch on `rx` produces no byte; `frame_cnt` wraps to 0 after 16 frames; `reset` pulsed mid-payload returns all outputs to 0 and the next frame is received cleanly.
